frame_writer: RTL and testbench

FRAME_WRITER -- requirements
Module: frame_writer

---
 rtl/frame_writer.sv | 85 ++++++++
 tb/tb_frame_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// frame_writer: streams pixels or a solid fill colour into a frame RAM write port.
// Optional FRAME_WRITER_SYNC_CHECK_EN checks s_last against the frame boundary.
module frame_writer #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 8192,
  parameter int FRAME_PIXELS = 6144,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [RAM_WIDTH-1:0] s_data,
  input  logic                 s_last,
  input  logic                 fill_start,
  input  logic [RAM_WIDTH-1:0] fill_color,
  output logic                 busy,
  output logic                 wea,
  output logic [AW-1:0]        addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 frame_done,
  output logic                 sync_err
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [RAM_WIDTH-1:0] color, wdata;
  logic wr, done, err, at_end, accept;
  assign at_end = ptr == AW'(FRAME_PIXELS - 1);
  assign s_ready = rsta_n && state == IDLE && !fill_start;
  assign accept = s_valid && s_ready;
  assign busy = state == FILL;
  always_comb begin
    state_nxt = state;
    ptr_nxt = ptr;
    wr = 1'b0;
    wdata = s_data;
    done = 1'b0;
    err = 1'b0;
    if (state == FILL) begin
      wr = 1'b1;
      wdata = color;
      ptr_nxt = at_end ? '0 : ptr + 1'b1;
      done = at_end;
      state_nxt = at_end ? IDLE : FILL;
    end else if (fill_start) begin
      state_nxt = FILL;
      ptr_nxt = '0;
    end else if (accept) begin
      wr = 1'b1;
      ptr_nxt = at_end ? '0 : ptr + 1'b1;
      done = at_end;
`ifdef FRAME_WRITER_SYNC_CHECK_EN
      // early s_last restarts the frame; missing s_last still wraps
      err = s_last != at_end;
      ptr_nxt = s_last ? '0 : ptr_nxt;
`endif
    end
  end
`ifndef FRAME_WRITER_SYNC_CHECK_EN
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state <= IDLE;
      ptr <= '0;
      color <= '0;
      wea <= 1'b0;
      addra <= '0;
      dina <= '0;
      frame_done <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      if (state == IDLE && fill_start) color <= fill_color;
      wea <= wr;
      if (wr) addra <= ptr;
      if (wr) dina <= wdata;
      frame_done <= done;
      sync_err <= err;
    end
  end
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed checks of reset, streaming, fill, sync check, mid-op reset and backpressure.
module tb_frame_writer;
  localparam int N = 6144;
  logic clka = 1'b0;
  logic rsta_n, s_valid, s_ready, s_last, fill_start, busy, wea, frame_done, sync_err;
  logic [15:0] s_data, fill_color, dina;
  logic [12:0] addra;
  int vecs = 0;
  int errs = 0;
  frame_writer dut (
    .clka(clka), .rsta_n(rsta_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .fill_start(fill_start), .fill_color(fill_color), .busy(busy),
    .wea(wea), .addra(addra), .dina(dina), .frame_done(frame_done), .sync_err(sync_err)
  );
  always #5 clka = ~clka;
  task automatic tick;
    @(posedge clka);
    #1;
  endtask
  task automatic do_reset;
    rsta_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    fill_start = 1'b0;
    s_data = '0;
    fill_color = '0;
    tick;
    tick;
    rsta_n = 1'b1;
  endtask
  task automatic test_reset;
    rsta_n = 1'b0;
    s_valid = 1'b1;
    s_data = 16'h1234;
    tick;
    tick;
    vecs++;
    if ({s_ready, wea, addra, busy, frame_done, sync_err} !== 18'b0) begin
      errs++;
      $display("FAIL reset_hold: ready=%b wea=%b addra=%0d busy=%b done=%b err=%b, want all 0",
               s_ready, wea, addra, busy, frame_done, sync_err);
    end
    rsta_n = 1'b1;
    s_data = 16'hAAAA;
    #1;
    vecs++;
    if (s_ready !== 1'b1 || wea !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: ready=%b wea=%b, want 1 0", s_ready, wea);
    end
    tick;
    s_valid = 1'b0;
    vecs++;
    if ({wea, addra, dina} !== {1'b1, 13'd0, 16'hAAAA}) begin
      errs++;
      $display("FAIL reset_first_write: wea=%b addra=%0d dina=%h, want 1 0 aaaa", wea, addra, dina);
    end
    tick;
    vecs++;
    if (wea !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle_wea: wea=%b, want 0", wea);
    end
  endtask
  task automatic test_stream;
    logic [12:0] a;
    do_reset;
    s_valid = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      s_data = 16'(i);
      s_last = (i == N - 1);
      tick;
      a = 13'(i % N);
      vecs++;
      if ({wea, addra, dina, frame_done, sync_err} !== {1'b1, a, 16'(i), i == N - 1, 1'b0}) begin
        errs++;
        $display("FAIL stream beat %0d: wea=%b addra=%0d dina=%0d done=%b err=%b, want 1 %0d %0d %b 0",
                 i, wea, addra, dina, frame_done, sync_err, a, i, i == N - 1);
      end
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    tick;
    vecs++;
    if ({wea, addra, frame_done} !== {1'b0, 13'd2, 1'b0}) begin
      errs++;
      $display("FAIL stream_hold: wea=%b addra=%0d done=%b, want 0 2 0", wea, addra, frame_done);
    end
  endtask
  task automatic test_fill;
    int busy_cycles = 0;
    int dones = 0;
    do_reset;
    s_valid = 1'b1;
    s_data = 16'h1111;
    fill_start = 1'b1;
    fill_color = 16'hF800;
    #1;
    vecs++;
    if (s_ready !== 1'b0) begin
      errs++;
      $display("FAIL fill_priority: s_ready=%b, want 0", s_ready);
    end
    tick;
    fill_start = 1'b0;
    fill_color = 16'h0000;
    if (busy === 1'b1) busy_cycles++;
    for (int k = 0; k < N; k++) begin
      if (k == 100) begin
        fill_start = 1'b1;
        fill_color = 16'h001F;
      end
      if (k == 101) fill_start = 1'b0;
      tick;
      if (busy === 1'b1) busy_cycles++;
      if (frame_done === 1'b1) dones++;
      vecs++;
      if ({wea, addra, dina, frame_done, s_ready} !== {1'b1, 13'(k), 16'hF800, k == N - 1, k == N - 1}) begin
        errs++;
        $display("FAIL fill step %0d: wea=%b addra=%0d dina=%h done=%b ready=%b, want 1 %0d f800 %b %b",
                 k, wea, addra, dina, frame_done, s_ready, k, k == N - 1, k == N - 1);
      end
    end
    vecs++;
    if (busy_cycles != N || dones != 1) begin
      errs++;
      $display("FAIL fill_counts: busy=%0d done=%0d, want %0d 1", busy_cycles, dones, N);
    end
    tick;
    s_valid = 1'b0;
    vecs++;
    if ({wea, addra, dina, busy} !== {1'b1, 13'd0, 16'h1111, 1'b0}) begin
      errs++;
      $display("FAIL fill_then_stream: wea=%b addra=%0d dina=%h busy=%b, want 1 0 1111 0", wea, addra, dina, busy);
    end
  endtask
  task automatic test_sync;
    do_reset;
    s_valid = 1'b1;
    for (int i = 0; i < 101; i++) begin
      s_data = 16'(i + 7);
      s_last = (i == 99);
      tick;
`ifdef FRAME_WRITER_SYNC_CHECK_EN
      vecs++;
      if ({addra, dina, sync_err, frame_done} !== {(i == 100) ? 13'd0 : 13'(i), 16'(i + 7), i == 99, 1'b0}) begin
        errs++;
        $display("FAIL sync_early beat %0d: addra=%0d dina=%0d err=%b done=%b, want %0d %0d %b 0",
                 i, addra, dina, sync_err, frame_done, (i == 100) ? 0 : i, i + 7, i == 99);
      end
`else
      vecs++;
      if ({addra, dina, sync_err, frame_done} !== {13'(i), 16'(i + 7), 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL sync_ignored beat %0d: addra=%0d dina=%0d err=%b done=%b, want %0d %0d 0 0",
                 i, addra, dina, sync_err, frame_done, i, i + 7);
      end
`endif
    end
`ifdef FRAME_WRITER_SYNC_CHECK_EN
    s_last = 1'b0;
    for (int i = 1; i < N + 1; i++) begin
      s_data = 16'(i);
      tick;
      vecs++;
      if ({addra, sync_err, frame_done} !== {(i == N) ? 13'd0 : 13'(i), i == N - 1, i == N - 1}) begin
        errs++;
        $display("FAIL sync_late beat %0d: addra=%0d err=%b done=%b, want %0d %b %b",
                 i, addra, sync_err, frame_done, (i == N) ? 0 : i, i == N - 1, i == N - 1);
      end
    end
`endif
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask
  task automatic test_midreset;
    do_reset;
    fill_start = 1'b1;
    fill_color = 16'h07E0;
    tick;
    fill_start = 1'b0;
    for (int k = 0; k < 3000; k++) tick;
    vecs++;
    if ({wea, addra, busy} !== {1'b1, 13'd2999, 1'b1}) begin
      errs++;
      $display("FAIL midreset_pre: wea=%b addra=%0d busy=%b, want 1 2999 1", wea, addra, busy);
    end
    rsta_n = 1'b0;
    #1;
    vecs++;
    if ({wea, busy, addra, dina, frame_done} !== 32'b0) begin
      errs++;
      $display("FAIL midreset_async: wea=%b busy=%b addra=%0d dina=%h done=%b, want all 0",
               wea, busy, addra, dina, frame_done);
    end
    tick;
    rsta_n = 1'b1;
    s_valid = 1'b1;
    s_data = 16'hBEEF;
    #1;
    vecs++;
    if (wea !== 1'b0) begin
      errs++;
      $display("FAIL midreset_release: wea=%b, want 0", wea);
    end
    tick;
    s_valid = 1'b0;
    vecs++;
    if ({wea, addra, dina, busy} !== {1'b1, 13'd0, 16'hBEEF, 1'b0}) begin
      errs++;
      $display("FAIL midreset_resume: wea=%b addra=%0d dina=%h busy=%b, want 1 0 beef 0", wea, addra, dina, busy);
    end
  endtask
  task automatic test_backpressure;
    logic [15:0] exp_q[$];
    int sent = 0;
    int writes = 0;
    do_reset;
    for (int i = 0; i < 41; i++) begin
      s_valid = (i % 2 == 0) && i < 40;
      s_data = 16'($urandom);
      if (s_valid) begin
        exp_q.push_back(s_data);
        sent++;
      end
      tick;
      if (wea === 1'b1) begin
        vecs++;
        if (writes >= exp_q.size() || addra !== 13'(writes) || dina !== exp_q[writes]) begin
          errs++;
          $display("FAIL bp write %0d: addra=%0d dina=%h, want %0d %h",
                   writes, addra, dina, writes, (writes < exp_q.size()) ? exp_q[writes] : 16'hxxxx);
        end
        writes++;
      end
    end
    vecs++;
    if (writes != 20 || sent != 20) begin
      errs++;
      $display("FAIL bp_count: writes=%0d sent=%0d, want 20 20", writes, sent);
    end
    s_valid = 1'b0;
  endtask
  initial begin
    rsta_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    fill_start = 1'b0;
    s_data = '0;
    fill_color = '0;
    test_reset;
    test_stream;
    test_fill;
    test_sync;
    test_midreset;
    test_backpressure;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
